// File: rtl/spi_reg_bridge_if.sv
// Bundles the SPI pins and the register write port of the SPI-to-register bridge.
// The bridge uses the slave modport; whatever drives SPI and watches writes uses master.
interface spi_reg_bridge_if;
    logic        sck_in;
    logic        cs_n_in;
    logic        mosi_in;
    logic [5:0]  addr_out;
    logic [15:0] data_out;
    logic        data_valid_out;
    logic        busy_out;
    logic        frame_err_out;

    modport slave (
        input  sck_in, cs_n_in, mosi_in,
        output addr_out, data_out, data_valid_out, busy_out, frame_err_out
    );

    modport master (
        output sck_in, cs_n_in, mosi_in,
        input  addr_out, data_out, data_valid_out, busy_out, frame_err_out
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 24-bit frames (cmd, addr, data) into single-cycle
// register write strobes, oversampling SCK/CS/MOSI in the clk_in domain.
module spi_reg_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    spi_reg_bridge_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] valid_sync;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sync_valid;
    logic                   sck_prev;
    logic                   sck_rise;
    logic [23:0]            shift_reg;
    logic [4:0]             bit_count;
    logic                   overflow;
    logic                   armed;
    logic                   pending;
    logic [5:0]             addr_q;
    logic [15:0]            data_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   err_q;

    assign sck_s      = sck_sync[SYNC_STAGES-1];
    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign sync_valid = valid_sync[SYNC_STAGES-1];
    assign sck_rise   = sck_s & ~sck_prev & ~cs_s;

    // valid_sync marks when the chains hold real pin levels rather than reset levels.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sck_sync   <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            valid_sync <= '0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], bus.sck_in};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n_in};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
            valid_sync <= {valid_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // A frame may only start once CS has genuinely been seen high, so a CS
    // held low across reset is ignored until it rises and falls again.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_count <= '0;
            overflow  <= 1'b0;
            armed     <= 1'b0;
            pending   <= 1'b0;
            sck_prev  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            sck_prev <= sck_s;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;

            if (pending) begin
                pending <= 1'b0;
                if (shift_reg[23:22] == 2'b00) begin
                    valid_q <= 1'b1;
                    addr_q  <= shift_reg[21:16];
                    data_q  <= shift_reg[15:0];
                end
            end

            case (state)
                IDLE: begin
                    if (armed && !cs_s) begin
                        shift_reg <= '0;
                        bit_count <= '0;
                        overflow  <= 1'b0;
                        armed     <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= SHIFT;
                    end else if (sync_valid && cs_s) begin
                        armed <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_s) begin
                        busy_q <= 1'b0;
                        err_q  <= (bit_count != 5'd0);
                        state  <= IDLE;
                    end else if (sck_rise) begin
                        shift_reg <= {shift_reg[22:0], mosi_s};
                        bit_count <= bit_count + 5'd1;
                        if (bit_count == 5'd23) begin
                            pending <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (cs_s) begin
                        busy_q <= 1'b0;
                        err_q  <= overflow;
                        state  <= IDLE;
                    end else if (sck_rise) begin
                        overflow <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.addr_out       = addr_q;
    assign bus.data_out       = data_q;
    assign bus.data_valid_out = valid_q;
    assign bus.busy_out       = busy_q;
    assign bus.frame_err_out  = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames plus random frames,
// with a frame-level reference model feeding scoreboard queues.
module tb_spi_reg_bridge;

    localparam int SYNC_STAGES = 2;
    localparam int MIN_GAP     = SYNC_STAGES + 2;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk_in;
    logic reset_n_in;
    spi_reg_bridge_if bus();

    int          checks;
    int          errors;
    int          half_clks;
    wr_t         exp_wr[$];
    int          exp_err[$];
    logic [5:0]  model_addr;
    logic [15:0] model_data;

    spi_reg_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Frame-level rules: a complete write frame produces one write; any frame
    // that was started but was short or overlong produces one error pulse.
    task automatic model_frame(input logic [23:0] frame, input int nbits);
        wr_t w;
        if (nbits >= 24 && frame[23:22] == 2'b00) begin
            w.addr = frame[21:16];
            w.data = frame[15:0];
            exp_wr.push_back(w);
            model_addr = frame[21:16];
            model_data = frame[15:0];
        end
        if (nbits > 0 && nbits != 24)
            exp_err.push_back(nbits);
    endtask

    task automatic send_bits(input logic [23:0] frame, input int first, input int last);
        for (int i = first; i < last; i++) begin
            bus.mosi_in = (i < 24) ? frame[23 - i] : 1'($urandom);
            repeat (half_clks) @(negedge clk_in);
            bus.sck_in = 1'b1;
            repeat (half_clks) @(negedge clk_in);
            bus.sck_in = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [23:0] frame, input int nbits, input int gap);
        model_frame(frame, nbits);
        @(negedge clk_in);
        bus.cs_n_in = 1'b0;
        repeat (half_clks) @(negedge clk_in);
        if (nbits >= 2) begin
            send_bits(frame, 0, 1);
            check_output("busy_mid_frame", 32'(bus.busy_out), 32'd1);
            send_bits(frame, 1, nbits);
        end else begin
            send_bits(frame, 0, nbits);
        end
        repeat (half_clks) @(negedge clk_in);
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        repeat (gap) @(negedge clk_in);
        if (gap >= 8) begin
            check_output("busy_idle", 32'(bus.busy_out), 32'd0);
            check_output("addr_hold", 32'(bus.addr_out), 32'(model_addr));
            check_output("data_hold", 32'(bus.data_out), 32'(model_data));
        end
    endtask

    // Monitor: every strobe or error pulse must match the oldest expectation.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_in);
            if (bus.data_valid_out === 1'b1) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL write_strobe: got write addr=%0h data=%0h, expected none",
                             bus.addr_out, bus.data_out);
                end else begin
                    w = exp_wr.pop_front();
                    if (bus.addr_out !== w.addr || bus.data_out !== w.data) begin
                        errors++;
                        $display("[TB] FAIL write_data: got addr=%0h data=%0h, expected addr=%0h data=%0h",
                                 bus.addr_out, bus.data_out, w.addr, w.data);
                    end
                end
            end
            if (bus.frame_err_out === 1'b1) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL frame_err: got pulse, expected none");
                end else begin
                    void'(exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        logic [23:0] frame;
        int          nbits;
        int          pick;

        checks      = 0;
        errors      = 0;
        half_clks   = 4;
        model_addr  = '0;
        model_data  = '0;
        reset_n_in  = 1'b0;
        bus.sck_in  = 1'b0;
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_output("reset_addr",  32'(bus.addr_out), 32'd0);
        check_output("reset_data",  32'(bus.data_out), 32'd0);
        check_output("reset_valid", 32'(bus.data_valid_out), 32'd0);
        check_output("reset_busy",  32'(bus.busy_out), 32'd0);
        check_output("reset_err",   32'(bus.frame_err_out), 32'd0);
        reset_n_in = 1'b1;
        repeat (10) @(negedge clk_in);

        apply_stimulus(24'h02_1234, 24, 12);
        apply_stimulus(24'h62_00AB, 24, 12);
        apply_stimulus(24'h21_0005, 10, 12);
        apply_stimulus(24'h21_0005, 24, 12);
        apply_stimulus(24'h08_00FF, 26, 12);

        // Reset in the middle of a frame with CS still low: nothing may come out.
        @(negedge clk_in);
        bus.cs_n_in = 1'b0;
        repeat (half_clks) @(negedge clk_in);
        send_bits(24'h24_0007, 0, 12);
        reset_n_in = 1'b0;
        model_addr = '0;
        model_data = '0;
        repeat (2) @(negedge clk_in);
        check_output("midreset_addr", 32'(bus.addr_out), 32'd0);
        check_output("midreset_busy", 32'(bus.busy_out), 32'd0);
        reset_n_in = 1'b1;
        send_bits(24'h24_0007, 12, 24);
        repeat (half_clks) @(negedge clk_in);
        bus.cs_n_in = 1'b1;
        repeat (12) @(negedge clk_in);
        check_output("postreset_busy", 32'(bus.busy_out), 32'd0);
        apply_stimulus(24'h24_0007, 24, 12);

        apply_stimulus(24'h00_1000, 24, MIN_GAP);
        apply_stimulus(24'h01_2000, 24, 12);

        for (int n = 0; n < 40; n++) begin
            frame[23:22] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            frame[21:16] = 6'($urandom);
            frame[15:0]  = 16'($urandom);
            pick = $urandom_range(0, 9);
            if (pick <= 5)      nbits = 24;
            else if (pick <= 7) nbits = $urandom_range(1, 23);
            else if (pick == 8) nbits = $urandom_range(25, 28);
            else                nbits = 0;
            half_clks = $urandom_range(4, 6);
            apply_stimulus(frame, nbits, ($urandom_range(0, 3) == 0) ? MIN_GAP : 12);
        end
        half_clks = 4;

        repeat (30) @(negedge clk_in);
        check_output("pending_writes", 32'(exp_wr.size()), 32'd0);
        check_output("pending_errors", 32'(exp_err.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flop synchronizer stages on each of sck_in, cs_n_in and mosi_in (legal range 2..3).
REQ-002 SHALL have port clk_in, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-003 SHALL have port reset_n_in, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port sck_in, input, 1 bit: SPI serial clock, asynchronous to clk_in.
REQ-005 SHALL have port cs_n_in, input, 1 bit: SPI chip select, active-low, asynchronous to clk_in.
REQ-006 SHALL have port mosi_in, input, 1 bit: SPI serial data in, asynchronous to clk_in.
REQ-007 SHALL have port addr_out, output, 6 bits: register address, feeding the tone engine's addr_in.
REQ-008 SHALL have port data_out, output, 16 bits: register write data, feeding the tone engine's data_in.
REQ-009 SHALL have port data_valid_out, output, 1 bit: one-clock write strobe, feeding the tone engine's data_valid_in.
REQ-010 SHALL have port busy_out, output, 1 bit: high while a frame is in progress (synchronized CS low).
REQ-011 SHALL have port frame_err_out, output, 1 bit: one-clock pulse flagging an aborted or overlong frame.

Function
REQ-012 SHALL pass sck_in, cs_n_in and mosi_in each through SYNC_STAGES flip-flops before any use; the synchronized signals are sck_s, cs_s and mosi_s.
REQ-013 SHALL detect an SCK rising edge as sck_s=1 with its previous registered value 0, considered only while cs_s=0 (SPI mode 0, MSB first).
REQ-014 SHALL require clk_in to run at least 8x the SCK frequency; behaviour below that ratio is undefined.
REQ-015 SHALL use a 24-bit frame: bits [23:22] are the command, [21:16] the address, [15:0] the data.
REQ-016 SHALL define command 2'b00 as a write; commands 01/10/11 SHALL be shifted in and counted, then discarded without a strobe.
REQ-017 SHALL implement state machine IDLE -> SHIFT -> DONE -> IDLE.
REQ-018 IDLE: cs_s falling SHALL clear the 24-bit shift register and the 5-bit bit counter, then enter SHIFT.
REQ-019 SHIFT: each detected edge SHALL shift mosi_s into bit 0 and increment the counter.
REQ-020 SHIFT: the edge that brings the counter to 24 SHALL enter DONE.
REQ-021 SHIFT: cs_s rising with counter <24 SHALL return to IDLE with no strobe and pulse frame_err_out for one clock, except counter=0, which SHALL return to IDLE silently.
REQ-022 In the clock cycle immediately after the 24th edge is shifted, for a write command, SHALL load addr_out/data_out and drive data_valid_out=1 for exactly that one cycle.
REQ-023 addr_out and data_out SHALL hold their last written values until the next valid write; they SHALL NOT change on non-write or aborted frames.
REQ-024 DONE: further edges SHALL be ignored; the first such edge SHALL set an internal overflow flag.
REQ-025 DONE: cs_s rising SHALL return to IDLE and pulse frame_err_out for one clock if the overflow flag is set; the write already issued SHALL stand.
REQ-026 SHALL issue at most one data_valid_out pulse per CS-low period.
REQ-027 Consecutive frames SHALL require CS to be high for at least SYNC_STAGES+2 clk_in cycles between them.
REQ-028 If an SCK edge and a cs_s rise are detected in the same cycle, the CS rise SHALL take priority and the edge SHALL be discarded.
REQ-029 busy_out SHALL equal 1 in SHIFT and DONE, and 0 in IDLE.

Reset
REQ-030 reset_n_in=0 SHALL immediately and asynchronously set state=IDLE, clear the counter, shift register and overflow flag, set all synchronizer flops to the idle levels (sck 0, cs 1, mosi 0), and set addr_out=6'h00, data_out=16'h0000, data_valid_out=0, busy_out=0, frame_err_out=0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no strobe and no frame_err_out pulse; after release, the bridge SHALL wait for a fresh CS falling edge.

Verification
REQ-032 Frame 0x02_1234 (cmd 00, addr 0x02, data 0x1234) -> exactly one data_valid_out pulse; addr_out=0x02, data_out=0x1234, held afterwards.
REQ-033 Frame 0x62_00AB (cmd 01) -> no strobe, no error; addr_out/data_out keep their prior values.
REQ-034 CS rises after 10 bits of 0x21_0005 -> no strobe, one frame_err_out pulse, busy_out drops; a following full frame 0x21_0005 -> strobe with addr 0x21, data 0x0005.
REQ-035 26 SCK edges sending 0x08_00FF plus 2 extra bits -> one strobe (addr 0x08, data 0x00FF) after bit 24; frame_err_out pulse at CS rise.
REQ-036 reset_n_in pulsed low after 12 bits, then a full frame 0x24_0007 -> first frame produces no strobe and no error; second produces a strobe with addr 0x24, data 0x0007.
REQ-037 Back-to-back frames 0x00_1000 and 0x01_2000 with minimum CS-high gap, clk_in = 8x SCK -> two strobes in order, with matching addr/data.
